ajuste_horario_loader: RTL

//  Time-set writer for the clock's BCD digit counters (minute units, minute tens, hour units,

---
 rtl/ajuste_horario_loader_pkg.sv | 56 +++++
 rtl/ajuste_horario_loader_bcd_digit_wrap.sv | 25 ++
 rtl/ajuste_horario_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ajuste_horario_loader_pkg.sv
// Shared encodings, digit limits and small helpers for the time-set loader.
package ajuste_horario_loader_pkg;

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_SET_HT = 3'd1;
  localparam logic [2:0] ST_SET_HU = 3'd2;
  localparam logic [2:0] ST_SET_MT = 3'd3;
  localparam logic [2:0] ST_SET_MU = 3'd4;
  localparam logic [2:0] ST_LOAD   = 3'd5;

  localparam logic [3:0] MU_MAX           = 4'd9;
  localparam logic [3:0] MT_MAX           = 4'd5;
  localparam logic [3:0] HU_MAX           = 4'd9;
  localparam logic [3:0] HU_MAX_AT_HT_MAX = 4'd3;
  localparam logic [3:0] PRESET_IDLE      = 4'hF;

  typedef struct packed {
    logic [3:0] ht;
    logic [3:0] hu;
    logic [3:0] mt;
    logic [3:0] mu;
  } shadow_t;

  typedef struct packed {
    logic [3:0] preset;
    logic [3:0] clear;
  } load_pair_t;

  // Digit index shown to the display blink logic for a given state.
  function automatic logic [1:0] sel_of_state(input logic [2:0] st);
    logic [1:0] sel;
    case (st)
      ST_SET_HT: sel = 2'd3;
      ST_SET_HU: sel = 2'd2;
      ST_SET_MT: sel = 2'd1;
      ST_SET_MU: sel = 2'd0;
      ST_LOAD:   sel = 2'd0;
      default:   sel = 2'd3;
    endcase
    return sel;
  endfunction

  // Active-low preset/clear pair that forces a JK counter to digit d.
  function automatic load_pair_t load_pair(input logic [3:0] d, input logic active);
    load_pair_t p;
    if (active) begin
      p.preset = ~d;
      p.clear  = d;
    end else begin
      p.preset = PRESET_IDLE;
      p.clear  = PRESET_IDLE;
    end
    return p;
  endfunction

endpackage

// File: rtl/ajuste_horario_loader_bcd_digit_wrap.sv
// One BCD digit incrementer: returns value+1, wrapping to 0 past max_val.
module bcd_digit_wrap
  import ajuste_horario_loader_pkg::*;
(
  input  logic [3:0] value,
  input  logic [3:0] max_val,
  input  logic       inc,
  output logic [3:0] next
);

  // A value already above the limit (limit lowered by the hour-tens digit) also wraps.
  always_comb begin
    next = value;
    if (inc) begin
      if (value >= max_val) begin
        next = 4'd0;
      end else begin
        next = value + 4'd1;
      end
    end else begin
      next = value;
    end
  end

endmodule

// File: rtl/ajuste_horario_loader.sv
// Time-set writer: edits shadow BCD digits with two buttons and pulses the
// counters' active-low preset/clear inputs to load them.
module ajuste_horario_loader
  import ajuste_horario_loader_pkg::*;
#(
  parameter int LOAD_CYCLES = 1,
  parameter int HT_MAX      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [3:0]  presetUm,
  output logic [3:0]  clearUm,
  output logic [3:0]  presetDm,
  output logic [3:0]  clearDm,
  output logic [3:0]  presetUh,
  output logic [3:0]  clearUh,
  output logic [3:0]  presetDh,
  output logic [3:0]  clearDh,
  output logic        set_active,
  output logic [1:0]  sel_digit,
  output logic [15:0] shadow
);

  localparam logic [3:0] HT_MAX_D  = 4'(HT_MAX);
  localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);

  logic       mode_q;
  logic       inc_q;
  logic [2:0] state;
  logic [2:0] state_n;
  logic [3:0] load_cnt;
  logic [3:0] load_cnt_n;
  shadow_t    dig;
  shadow_t    dig_n;

  logic       mode_edge;
  logic       inc_edge;
  logic       inc_ht;
  logic       inc_hu;
  logic       inc_mt;
  logic       inc_mu;
  logic [3:0] hu_limit;
  logic [3:0] ht_wrap;
  logic [3:0] hu_wrap;
  logic [3:0] mt_wrap;
  logic [3:0] mu_wrap;
  logic       load_n;
  load_pair_t lp_um;
  load_pair_t lp_dm;
  load_pair_t lp_uh;
  load_pair_t lp_dh;

  // A simultaneous mode edge wins; the inc edge of that cycle is dropped.
  assign mode_edge = btn_mode & ~mode_q;
  assign inc_edge  = btn_inc & ~inc_q & ~mode_edge;

  assign inc_ht = inc_edge & (state == ST_SET_HT);
  assign inc_hu = inc_edge & (state == ST_SET_HU);
  assign inc_mt = inc_edge & (state == ST_SET_MT);
  assign inc_mu = inc_edge & (state == ST_SET_MU);

  assign hu_limit = (dig.ht == HT_MAX_D) ? HU_MAX_AT_HT_MAX : HU_MAX;

  bcd_digit_wrap u_wrap_ht (.value(dig.ht), .max_val(HT_MAX_D), .inc(inc_ht), .next(ht_wrap));
  bcd_digit_wrap u_wrap_hu (.value(dig.hu), .max_val(hu_limit), .inc(inc_hu), .next(hu_wrap));
  bcd_digit_wrap u_wrap_mt (.value(dig.mt), .max_val(MT_MAX),   .inc(inc_mt), .next(mt_wrap));
  bcd_digit_wrap u_wrap_mu (.value(dig.mu), .max_val(MU_MAX),   .inc(inc_mu), .next(mu_wrap));

  // Raising hour tens to its maximum pulls an out-of-range hour unit down to 3.
  always_comb begin
    dig_n    = dig;
    dig_n.ht = ht_wrap;
    dig_n.mt = mt_wrap;
    dig_n.mu = mu_wrap;
    if (inc_ht && (ht_wrap == HT_MAX_D) && (dig.hu > HU_MAX_AT_HT_MAX)) begin
      dig_n.hu = HU_MAX_AT_HT_MAX;
    end else begin
      dig_n.hu = hu_wrap;
    end
  end

  always_comb begin
    state_n    = state;
    load_cnt_n = load_cnt;
    case (state)
      ST_RUN: begin
        if (mode_edge) begin
          state_n = ST_SET_HT;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_SET_HT, ST_SET_HU, ST_SET_MT: begin
        if (mode_edge) begin
          state_n = state + 3'd1;
        end else begin
          state_n = state;
        end
      end
      ST_SET_MU: begin
        if (mode_edge) begin
          state_n    = ST_LOAD;
          load_cnt_n = LOAD_LAST;
        end else begin
          state_n = ST_SET_MU;
        end
      end
      ST_LOAD: begin
        if (load_cnt == 4'd0) begin
          state_n = ST_RUN;
        end else begin
          load_cnt_n = load_cnt - 4'd1;
        end
      end
      default: begin
        state_n    = ST_RUN;
        load_cnt_n = 4'd0;
      end
    endcase
  end

  assign load_n = (state_n == ST_LOAD);
  assign lp_um  = load_pair(dig_n.mu, load_n);
  assign lp_dm  = load_pair(dig_n.mt, load_n);
  assign lp_uh  = load_pair(dig_n.hu, load_n);
  assign lp_dh  = load_pair(dig_n.ht, load_n);

  // Outputs are registered from the next-state view so they track the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= 1'b0;
      inc_q      <= 1'b0;
      state      <= ST_RUN;
      load_cnt   <= 4'd0;
      dig        <= '0;
      set_active <= 1'b0;
      sel_digit  <= 2'd3;
      presetUm   <= PRESET_IDLE;
      clearUm    <= PRESET_IDLE;
      presetDm   <= PRESET_IDLE;
      clearDm    <= PRESET_IDLE;
      presetUh   <= PRESET_IDLE;
      clearUh    <= PRESET_IDLE;
      presetDh   <= PRESET_IDLE;
      clearDh    <= PRESET_IDLE;
    end else begin
      mode_q     <= btn_mode;
      inc_q      <= btn_inc;
      state      <= state_n;
      load_cnt   <= load_cnt_n;
      dig        <= dig_n;
      set_active <= (state_n != ST_RUN);
      sel_digit  <= sel_of_state(state_n);
      presetUm   <= lp_um.preset;
      clearUm    <= lp_um.clear;
      presetDm   <= lp_dm.preset;
      clearDm    <= lp_dm.clear;
      presetUh   <= lp_uh.preset;
      clearUh    <= lp_uh.clear;
      presetDh   <= lp_dh.preset;
      clearDh    <= lp_dh.clear;
    end
  end

  assign shadow = dig;

endmodule
